spi_frame_regs: RTL and testbench

SPI_FRAME_REGS -- requirements
Module: spi_frame_regs

---
 rtl/spi_frame_regs.sv | 156 +++++++++++++++
 tb/tb_spi_frame_regs.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_regs.sv
// spi_frame_regs: SPI mode-0 slave exchanging fixed-length checksummed frames;
// received fields sit in shadows and reach vel/dout/cfg only when a frame is accepted.
module spi_frame_regs #(
    parameter int N_CH   = 4,
    parameter int POS_W  = 21,
    parameter int VEL_W  = 12,
    parameter int DIN_W  = 16,
    parameter int DOUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    SCK,
    input  logic                    SSEL,
    input  logic                    MOSI,
    output logic                    MISO,
    input  logic [N_CH*POS_W-1:0]   pos,
    input  logic [DIN_W-1:0]        din,
    output logic [N_CH*VEL_W-1:0]   vel,
    output logic [DOUT_W-1:0]       dout,
    output logic [15:0]             cfg,
    output logic                    commit,
    output logic                    frame_err,
    output logic [7:0]              err_cnt
);
    localparam logic [5:0] NB = 6'(4*N_CH);
    localparam logic [5:0] L  = NB + 6'd5;

    logic [2:0] sck_s, ssel_s;
    logic [1:0] mosi_s;
    logic       in_frame, load_pend, sum_ok;
    logic [2:0] bit_cnt;
    logic [5:0] byte_cnt;
    logic [6:0] rx_sr;
    logic [7:0] tx_sr, rx_sum, tx_sum, seq, err_snap, seq_snap, tx_next;
    logic [N_CH*POS_W-1:0] pos_snap;
    logic [DIN_W-1:0]      din_snap;
    logic [N_CH*VEL_W-1:0] vel_sh;
    logic [DOUT_W-1:0]     dout_sh;
    logic [15:0]           cfg_sh, din16;
    logic [23:0]           p24;
    logic [7:0]            rx_byte;
    logic sck_rise, sck_fall, ssel_fall, ssel_rise, accept;

    // Reset synchronisers low so a high SSEL at release never looks like a frame boundary
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sck_s  <= '0;
            ssel_s <= '0;
            mosi_s <= '0;
        end else begin
            sck_s  <= {sck_s[1:0], SCK};
            ssel_s <= {ssel_s[1:0], SSEL};
            mosi_s <= {mosi_s[0], MOSI};
        end

    assign sck_rise  = in_frame & sck_s[1] & ~sck_s[2];
    assign sck_fall  = in_frame & ~sck_s[1] & sck_s[2];
    assign ssel_fall = ~ssel_s[1] & ssel_s[2];
    assign ssel_rise = in_frame & ssel_s[1] & ~ssel_s[2];
    assign rx_byte   = {rx_sr, mosi_s[1]};
    assign accept    = ssel_rise & (byte_cnt == L) & (bit_cnt == 3'd0) & sum_ok;
    assign MISO      = tx_sr[7];
    assign din16     = 16'(din_snap);

    always_comb begin
        p24 = '0;
        for (int k = 0; k < N_CH; k++)
            if (byte_cnt[5:2] == 4'(k)) p24 = 24'(pos_snap[k*POS_W +: POS_W]);
        tx_next = byte_cnt < NB ? (byte_cnt[1:0] == 2'd3 ? 8'h00 : p24[8*byte_cnt[1:0] +: 8]) :
                  byte_cnt == NB ? din16[7:0] :
                  byte_cnt == NB + 6'd1 ? din16[15:8] :
                  byte_cnt == NB + 6'd2 ? err_snap :
                  byte_cnt == NB + 6'd3 ? seq_snap :
                  byte_cnt == NB + 6'd4 ? tx_sum : 8'h00;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            in_frame  <= 1'b0;
            load_pend <= 1'b0;
            sum_ok    <= 1'b0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            rx_sum    <= '0;
            tx_sum    <= '0;
            seq       <= '0;
            err_snap  <= '0;
            seq_snap  <= '0;
            pos_snap  <= '0;
            din_snap  <= '0;
            vel_sh    <= '0;
            dout_sh   <= '0;
            cfg_sh    <= '0;
            vel       <= '0;
            dout      <= '0;
            cfg       <= '0;
            err_cnt   <= '0;
            commit    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            commit    <= 1'b0;
            frame_err <= 1'b0;
            if (ssel_fall) begin
                in_frame  <= 1'b1;
                load_pend <= 1'b0;
                sum_ok    <= 1'b0;
                bit_cnt   <= '0;
                byte_cnt  <= '0;
                rx_sum    <= '0;
                tx_sr     <= pos[7:0];
                tx_sum    <= pos[7:0];
                pos_snap  <= pos;
                din_snap  <= din;
                err_snap  <= err_cnt;
                seq_snap  <= seq;
            end else if (ssel_rise) begin
                in_frame  <= 1'b0;
                commit    <= accept;
                frame_err <= ~accept;
                if (accept) begin
                    vel  <= vel_sh;
                    dout <= dout_sh;
                    cfg  <= cfg_sh;
                    seq  <= seq + 8'd1;
                end else if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else begin
                if (sck_rise) begin
                    rx_sr   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        load_pend <= 1'b1;
                        byte_cnt  <= byte_cnt == L + 6'd1 ? byte_cnt : byte_cnt + 6'd1;
                        if (byte_cnt < L - 6'd1) rx_sum <= rx_sum + rx_byte;
                        if (byte_cnt == L - 6'd1) sum_ok <= rx_byte == rx_sum;
                        for (int k = 0; k < N_CH; k++) begin
                            if (byte_cnt == 6'(4*k)) vel_sh[k*VEL_W +: 8] <= rx_byte;
                            if (byte_cnt == 6'(4*k+1)) vel_sh[k*VEL_W+8 +: VEL_W-8] <= rx_byte[VEL_W-9:0];
                        end
                        if (byte_cnt == NB) dout_sh[7:0] <= rx_byte;
                        if (byte_cnt == NB + 6'd1) dout_sh[DOUT_W-1:8] <= rx_byte[DOUT_W-9:0];
                        if (byte_cnt == NB + 6'd2) cfg_sh[7:0] <= rx_byte;
                        if (byte_cnt == NB + 6'd3) cfg_sh[15:8] <= rx_byte;
                    end
                end
                if (sck_fall) begin
                    load_pend <= 1'b0;
                    if (load_pend) begin
                        tx_sr  <= tx_next;
                        tx_sum <= tx_sum + tx_next;
                    end else tx_sr <= {tx_sr[6:0], 1'b0};
                end
            end
        end
endmodule

// File: tb/tb_spi_frame_regs.sv
// tb_spi_frame_regs: randomized SPI frames against a byte-level frame model.
module tb_spi_frame_regs;
    localparam int N = 4, L = 4*N + 5, H = 4;
    logic clk = 0, rst = 1, SCK = 0, SSEL = 1, MOSI = 0, MISO;
    logic [N*21-1:0] pos = '0;
    logic [15:0] din = '0, dout, cfg;
    logic [N*12-1:0] vel;
    logic commit, frame_err;
    logic [7:0] err_cnt;
    int npass = 0, ntot = 0, n_commit = 0, n_ferr = 0, n_both = 0;
    logic [7:0] mo [0:40];
    logic [7:0] mi [0:40];
    logic [11:0] m_vel [0:N-1];
    logic [15:0] m_dout, m_cfg;
    int m_err = 0, m_seq = 0, m_commit = 0, m_ferr = 0;

    always #5 clk = ~clk;

    spi_frame_regs dut (.clk(clk), .rst(rst), .SCK(SCK), .SSEL(SSEL), .MOSI(MOSI), .MISO(MISO),
        .pos(pos), .din(din), .vel(vel), .dout(dout), .cfg(cfg), .commit(commit),
        .frame_err(frame_err), .err_cnt(err_cnt));

    always @(negedge clk) begin
        if (commit) n_commit++;
        if (frame_err) n_ferr++;
        if (commit && frame_err) n_both++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_vel[k] = '0;
        m_dout = '0; m_cfg = '0; m_err = 0; m_seq = 0;
    endtask

    task automatic check_outs();
        logic [N*12-1:0] ev;
        for (int k = 0; k < N; k++) ev[k*12 +: 12] = m_vel[k];
        chk("vel", vel, ev);
        chk("dout", dout, m_dout);
        chk("cfg", cfg, m_cfg);
        chk("err_cnt", err_cnt, m_err);
        chk("commits", n_commit, m_commit);
        chk("frame_errs", n_ferr, m_ferr);
        chk("no_overlap", n_both, 0);
    endtask

    task automatic build(input logic [7:0] bad);
        logic [7:0] s = 0;
        for (int i = 0; i < L - 1; i++) s += mo[i];
        mo[L-1] = s + bad;
    endtask

    task automatic build_rand(input logic [7:0] bad);
        for (int i = 0; i <= 40; i++) mo[i] = 8'($urandom);
        build(bad);
    endtask

    task automatic send_byte(input logic [7:0] b, input int nb, output logic [7:0] r);
        r = 0;
        for (int i = 0; i < nb; i++) begin
            MOSI = b[7-i];
            repeat (H) @(negedge clk);
            r = {r[6:0], MISO};
            SCK = 1;
            repeat (H) @(negedge clk);
            SCK = 0;
        end
    endtask

    task automatic frame(input int nb, input int nbits, input int pchg);
        logic [7:0] r;
        SSEL = 0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            if (i == pchg) pos = '0;
            send_byte(mo[i], 8, r);
            mi[i] = r;
        end
        if (nbits > 0) send_byte(mo[nb], nbits, r);
        repeat (H) @(negedge clk);
        SSEL = 1;
        repeat (2*H) @(negedge clk);
    endtask

    // Expected MISO comes from the pins at frame start; acceptance from the byte list alone
    task automatic run(input int nb, input int nbits, input int pchg);
        logic [7:0] e [0:40];
        logic [7:0] s;
        logic [23:0] p;
        bit ok;
        for (int i = 0; i <= 40; i++) e[i] = 0;
        for (int k = 0; k < N; k++) begin
            p = 24'(pos[k*21 +: 21]);
            for (int j = 0; j < 3; j++) e[4*k+j] = p[8*j +: 8];
        end
        e[4*N] = din[7:0]; e[4*N+1] = din[15:8];
        e[4*N+2] = 8'(m_err); e[4*N+3] = 8'(m_seq);
        s = 0;
        for (int i = 0; i < L - 1; i++) s += e[i];
        e[L-1] = s;
        frame(nb, nbits, pchg);
        for (int i = 0; i < nb; i++) chk($sformatf("miso_b%0d", i), mi[i], e[i]);
        s = 0;
        for (int i = 0; i < L - 1; i++) s += mo[i];
        ok = nb == L && nbits == 0 && mo[L-1] == s;
        if (ok) begin
            for (int k = 0; k < N; k++) m_vel[k] = 12'({mo[4*k+1], mo[4*k]});
            m_dout = {mo[4*N+1], mo[4*N]};
            m_cfg = {mo[4*N+3], mo[4*N+2]};
            m_seq = (m_seq + 1) % 256;
            m_commit++;
        end else begin
            m_err = m_err == 255 ? 255 : m_err + 1;
            m_ferr++;
        end
        check_outs();
    endtask

    initial begin
        logic [7:0] r;
        int mode, nb, nbits;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_vel", vel, 0);
        chk("rst_miso", MISO, 0);
        chk("rst_commit", commit, 0);
        chk("rst_ferr", frame_err, 0);
        rst = 0;
        repeat (2*H) @(negedge clk);
        check_outs();

        for (int i = 0; i <= 40; i++) mo[i] = 0;
        mo[0] = 8'h23; mo[1] = 8'h01;
        mo[4*N] = 8'hEF; mo[4*N+1] = 8'hBE; mo[4*N+2] = 8'h05; mo[4*N+3] = 8'h80;
        build(0);
        run(L, 0, -1);
        chk("vel0_123", vel[11:0], 12'h123);
        chk("dout_beef", dout, 16'hBEEF);
        chk("cfg_8005", cfg, 16'h8005);
        mo[L-1] = mo[L-1] + 8'd1;
        run(L, 0, -1);
        chk("seq_byte", mi[4*N+3], 8'h01);
        chk("bad_sum_errcnt", err_cnt, 1);
        chk("bad_sum_dout_held", dout, 16'hBEEF);
        build_rand(0);
        run(L - 1, 0, -1);
        run(L, 3, -1);
        chk("short_long_errcnt", err_cnt, 3);

        pos = '0;
        pos[20:0] = 21'h1ABCDE;
        din = 16'($urandom);
        build_rand(0);
        run(L, 0, 1);
        chk("snap_b0", mi[0], 8'hDE);
        chk("snap_b1", mi[1], 8'hBC);
        chk("snap_b2", mi[2], 8'h1A);
        chk("snap_b3", mi[3], 8'h00);

        for (int t = 0; t < 20; t++) begin
            pos = (N*21)'({$urandom, $urandom, $urandom});
            din = 16'($urandom);
            mode = $urandom_range(0, 5);
            nb = L; nbits = 0;
            build_rand(mode == 3 ? 8'($urandom_range(1, 255)) : 8'd0);
            if (mode == 4) begin nb = $urandom_range(1, L - 1); nbits = $urandom_range(0, 7); end
            if (mode == 5) begin
                if ($urandom_range(0, 1) == 1) nb = L + 1;
                else nbits = $urandom_range(1, 7);
            end
            run(nb, nbits, -1);
        end

        for (int t = 0; t < 256; t++) run(0, 0, -1);
        chk("errcnt_sat", err_cnt, 255);

        build_rand(0);
        run(L, 0, -1);
        build_rand(0);
        SSEL = 0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < 5; i++) send_byte(mo[i], 8, r);
        rst = 1;
        @(negedge clk);
        chk("midrst_vel", vel, 0);
        chk("midrst_dout", dout, 0);
        chk("midrst_cfg", cfg, 0);
        chk("midrst_errcnt", err_cnt, 0);
        chk("midrst_miso", MISO, 0);
        rst = 0;
        repeat (H) @(negedge clk);
        SSEL = 1;
        repeat (2*H) @(negedge clk);
        model_reset();
        check_outs();
        pos = (N*21)'({$urandom, $urandom, $urandom});
        build_rand(0);
        run(L, 0, -1);

        build_rand(0);
        SSEL = 0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < L; i++) send_byte(mo[i], 8, r);
        repeat (H) @(negedge clk);
        SSEL = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        repeat (2*H) @(negedge clk);
        model_reset();
        check_outs();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
